// File: rtl/return_addr_stack_pkg.sv
// Shared types and configuration for the frontend return-address stack.
package return_addr_stack_pkg;

  localparam int unsigned ALEN      = 64;
  localparam int unsigned RAS_DEPTH = 8;

  typedef struct packed {
    logic            push;
    logic            pop;
    logic [ALEN-1:0] addr;
  } ras_op_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating occupancy and an override load path.
module ras_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  ras_op_t                            op_i,
  input  logic                               load_i,
  input  logic [DEPTH-1:0][ALEN-1:0]         load_entries_i,
  input  logic [$clog2(DEPTH)-1:0]           load_tos_i,
  input  logic [$clog2(DEPTH):0]             load_cnt_i,
  output logic [ALEN-1:0]                    tos_entry_o,
  output logic [$clog2(DEPTH):0]             cnt_o,
  output logic                               full_o,
  output logic [DEPTH-1:0][ALEN-1:0]         nxt_entries_o,
  output logic [$clog2(DEPTH)-1:0]           nxt_tos_o,
  output logic [$clog2(DEPTH):0]             nxt_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][ALEN-1:0] entries_q, entries_d;
  logic [PW-1:0]              tos_q, tos_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  // Pop is applied before push so a simultaneous call+ret replaces the top entry.
  always_comb begin
    entries_d = entries_q;
    tos_d     = tos_q;
    cnt_d     = cnt_q;
    if (op_i.pop && (cnt_d != '0)) begin
      tos_d = tos_d - 1'b1;
      cnt_d = cnt_d - 1'b1;
    end
    if (op_i.push) begin
      tos_d            = tos_d + 1'b1;
      entries_d[tos_d] = op_i.addr;
      if (cnt_d != CW'(DEPTH)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
    if (load_i) begin
      entries_d = load_entries_i;
      tos_d     = load_tos_i;
      cnt_d     = load_cnt_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '0;
      tos_q     <= '0;
      cnt_q     <= '0;
    end else begin
      entries_q <= entries_d;
      tos_q     <= tos_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tos_entry_o   = (cnt_q != '0) ? entries_q[tos_q] : '0;
  assign cnt_o         = cnt_q;
  assign full_o        = (cnt_q == CW'(DEPTH));
  assign nxt_entries_o = entries_d;
  assign nxt_tos_o     = tos_d;
  assign nxt_cnt_o     = cnt_d;

endmodule

// File: rtl/return_addr_stack.sv
// Frontend RAS: speculative stack fed by fetch predictions, committed stack fed by BU confirms.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic                     fetch_call_i,
  input  logic                     fetch_ret_i,
  input  logic [ALEN-1:0]          fetch_link_addr_i,
  output logic                     pred_ret_valid_o,
  output logic [ALEN-1:0]          pred_ret_addr_o,
  input  logic                     bu_call_confirm_i,
  input  logic                     bu_ret_confirm_i,
  input  logic [ALEN-1:0]          bu_link_addr_i,
  input  logic                     bu_mispredict_i,
  output logic [$clog2(DEPTH):0]   ras_spec_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ras_op_t fetch_op, bu_op;
  logic    restore;

  logic [DEPTH-1:0][ALEN-1:0] com_nxt_entries, spec_nxt_entries;
  logic [PW-1:0]              com_nxt_tos, spec_nxt_tos;
  logic [CW-1:0]              com_nxt_cnt, spec_nxt_cnt;
  logic [CW-1:0]              com_cnt, spec_cnt;
  logic [ALEN-1:0]            com_tos_entry;
  logic                       com_full, spec_full;

  assign restore = flush_i | bu_mispredict_i;

  always_comb begin
    fetch_op      = '0;
    fetch_op.push = fetch_valid_i & fetch_call_i;
    fetch_op.pop  = fetch_valid_i & fetch_ret_i;
    fetch_op.addr = fetch_link_addr_i;
    bu_op         = '0;
    bu_op.push    = bu_call_confirm_i;
    bu_op.pop     = bu_ret_confirm_i;
    bu_op.addr    = bu_link_addr_i;
  end

  ras_stack #(.DEPTH(DEPTH)) u_committed (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .op_i           (bu_op),
    .load_i         (1'b0),
    .load_entries_i ('0),
    .load_tos_i     ('0),
    .load_cnt_i     ('0),
    .tos_entry_o    (com_tos_entry),
    .cnt_o          (com_cnt),
    .full_o         (com_full),
    .nxt_entries_o  (com_nxt_entries),
    .nxt_tos_o      (com_nxt_tos),
    .nxt_cnt_o      (com_nxt_cnt)
  );

  // Restore loads the committed next state, so a same-cycle confirm is included.
  ras_stack #(.DEPTH(DEPTH)) u_speculative (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .op_i           (fetch_op),
    .load_i         (restore),
    .load_entries_i (com_nxt_entries),
    .load_tos_i     (com_nxt_tos),
    .load_cnt_i     (com_nxt_cnt),
    .tos_entry_o    (pred_ret_addr_o),
    .cnt_o          (spec_cnt),
    .full_o         (spec_full),
    .nxt_entries_o  (spec_nxt_entries),
    .nxt_tos_o      (spec_nxt_tos),
    .nxt_cnt_o      (spec_nxt_cnt)
  );

  assign pred_ret_valid_o = (spec_cnt != '0);
  assign ras_spec_cnt_o   = spec_cnt;

  logic unused_dbg;
  assign unused_dbg = ^{com_tos_entry, com_cnt, com_full, spec_full,
                        spec_nxt_entries, spec_nxt_tos, spec_nxt_cnt};

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Frontend return-address stack (RAS) that receives the branch unit's call/return confirmations and link address, i.e. it is the consumer end of the BU→frontend confirm interface.
- Holds two stacks:
  - a speculative stack, updated by fetch-time call/return predictions, which supplies predicted return targets to PC generation;
  - a committed stack, updated only by BU confirmations.
- On misprediction or pipeline flush, the speculative stack is restored from the committed stack.

Parameters:
- DEPTH, 8, number of stack entries; must be a power of 2, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; restore speculative stack from committed stack
- fetch_valid_i  in  1  fetch-side prediction event valid this cycle
- fetch_call_i  in  1  predicted instruction is a call (push)
- fetch_ret_i  in  1  predicted instruction is a return (pop)
- fetch_link_addr_i  in  len5_pkg::ALEN  address pushed on a speculative call (pc + 4)
- pred_ret_valid_o  out  1  speculative stack non-empty; pred_ret_addr_o is meaningful
- pred_ret_addr_o  out  len5_pkg::ALEN  speculative top-of-stack
- bu_call_confirm_i  in  1  BU confirms an executed call
- bu_ret_confirm_i  in  1  BU confirms an executed return
- bu_link_addr_i  in  len5_pkg::ALEN  link address of the confirmed call
- bu_mispredict_i  in  1  BU resolution valid and mispredicted; restore speculative stack
- ras_spec_cnt_o  out  $clog2(DEPTH)+1  speculative occupancy (debug/verification)

Behaviour:
- Reset (asynchronous, rst_ni low):
  - both top-of-stack pointers = 0;
  - both counts = 0;
  - all entries = 0;
  - pred_ret_valid_o = 0, pred_ret_addr_o = 0, ras_spec_cnt_o = 0.
- Storage and pointers:
  - Each stack is circular, DEPTH entries, with tos pointer modulo DEPTH and count saturating at DEPTH.
  - Push: tos <= tos+1; entry[tos+1] <= addr; count <= min(count+1, DEPTH).
  - On overflow the oldest entry is silently overwritten; no error is raised.
  - Pop when count > 0: tos <= tos-1; count <= count-1.
  - Pop when count == 0: no-op (pointer unchanged, no wrap).
- Pop and push in the same cycle (call and ret both asserted):
  - Pop is applied first, then push. This is the RISC-V coroutine hint.
  - Net effect: entry[tos] replaced; count unchanged if > 0, 1 if it was 0.
- Speculative stack update:
  - Updated when fetch_valid_i is high, using fetch_call_i / fetch_ret_i.
  - Fetch inputs are ignored when fetch_valid_i is low.
- Committed stack update:
  - Updated by bu_call_confirm_i (push of bu_link_addr_i) and bu_ret_confirm_i (pop).
  - Confirms are independent of flush_i and bu_mispredict_i.
  - A confirm in the same cycle as a restore is applied to the committed stack first.
- Restore (flush_i or bu_mispredict_i high):
  - Next-state speculative tos, count and all entries <= next-state committed tos, count and entries (i.e. including any same-cycle confirm).
  - Fetch events in the same cycle are discarded.
  - flush_i and bu_mispredict_i together behave as a single restore.
- Outputs:
  - pred_ret_addr_o = spec entry[spec tos], read combinationally from registers; = 0 when spec count == 0.
  - pred_ret_valid_o = (spec count != 0).
  - Latency: a push in cycle N is visible at the output in cycle N+1; a restore in cycle N takes effect in cycle N+1.
- Handshake: no backpressure in either direction; the block is always ready.
- Reset mid-operation: all state is cleared immediately; no pending confirm survives.

Decomposition:
- len5_config_pkg: RAS_DEPTH constant (default 8), which feeds DEPTH at frontend instantiation.
- fetch_pkg: typedef ras_op_t (packed: push, pop, addr[ALEN]) shared by the fetch and BU sides.
- Sub-module ras_stack #(DEPTH):
  - inputs: clk_i, rst_ni, op (ras_op_t), load_i, load_entries_i/load_tos_i/load_cnt_i;
  - outputs: tos entry, count, full state.
  - Instantiated twice: committed (load_i = 0) and speculative (loaded from the committed next state on restore).

Test Plan:
- Reset then speculative call with fetch_link_addr_i=0x1004 -> next cycle pred_ret_valid_o=1, pred_ret_addr_o=0x1004, ras_spec_cnt_o=1.
- Speculative calls 0x100, 0x200, 0x300, then speculative ret -> pred_ret_addr_o=0x200, count=2; two more rets -> valid=0, addr=0; a third ret -> no change, count stays 0.
- DEPTH=8, push 0x10..0x90 (9 calls) -> count saturates at 8, top=0x90; 8 pops return 0x90..0x20, then valid=0 (0x10 was lost).
- Confirm call 0xA00 (committed), then speculative calls 0xB00, 0xC00, then bu_mispredict_i -> next cycle top=0xA00, count=1.
- bu_call_confirm_i with 0xD00 in the same cycle as flush_i and fetch call 0xE00 -> next cycle top=0xD00, count=1; 0xE00 discarded.
- fetch_call_i and fetch_ret_i together with stack [0x40, 0x50], link 0x60 -> top=0x60, below it 0x40, count=2; the same with an empty stack -> count=1, top=0x60.
